// File: rtl/gpi_debounce.sv
// rtl/gpi_debounce.sv - N-channel pad synchroniser and debouncer with rise/fall pulses
// Define GPI_DEBOUNCE_IRQ_EN to add sticky, clearable per-channel edge interrupts.
module gpi_debounce #(
  parameter int               Width          = 7,
  parameter int               ClockFrequency = 50_000_000,
  parameter int               DebounceUs     = 10,
  parameter int               SyncStages     = 2,
  parameter logic [Width-1:0] ResetValue     = '0
) (
  input  logic             clk_sys_i,
  input  logic             rst_sys_ni,
  input  logic [Width-1:0] gpi_i,
  output logic [Width-1:0] gpi_o,
  output logic [Width-1:0] rise_o,
  output logic [Width-1:0] fall_o
`ifdef GPI_DEBOUNCE_IRQ_EN
  ,
  input  logic [Width-1:0] irq_rise_en_i,
  input  logic [Width-1:0] irq_fall_en_i,
  input  logic [Width-1:0] irq_clear_i,
  output logic [Width-1:0] irq_pending_o,
  output logic             irq_o
`endif
);

  localparam int DebounceRaw    = (ClockFrequency / 1_000_000) * DebounceUs;
  localparam int DebounceCycles = (DebounceRaw < 1) ? 1 : DebounceRaw;
  localparam int CntW           = $clog2(DebounceCycles + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(DebounceCycles - 1);

  if (SyncStages < 2 || SyncStages > 4) begin : g_bad_sync_stages
    $error("gpi_debounce: SyncStages must be in 2..4");
  end

  logic [Width-1:0] sync_q [SyncStages];
  logic [Width-1:0] sync_s;
  logic [CntW-1:0]  cnt_q  [Width];

  always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
    if (!rst_sys_ni) begin
      for (int i = 0; i < SyncStages; i++) sync_q[i] <= ResetValue;
    end else begin
      sync_q[0] <= gpi_i;
      for (int i = 1; i < SyncStages; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign sync_s = sync_q[SyncStages-1];

  // The count only advances while the synchronised input disagrees with the
  // stable output, so it can never pass CntLast.
  always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
    if (!rst_sys_ni) begin
      gpi_o  <= ResetValue;
      rise_o <= '0;
      fall_o <= '0;
      for (int c = 0; c < Width; c++) cnt_q[c] <= '0;
    end else begin
      rise_o <= '0;
      fall_o <= '0;
      for (int c = 0; c < Width; c++) begin
        if (sync_s[c] == gpi_o[c]) begin
          cnt_q[c] <= '0;
        end else if (cnt_q[c] == CntLast) begin
          cnt_q[c]  <= '0;
          gpi_o[c]  <= sync_s[c];
          rise_o[c] <= sync_s[c];
          fall_o[c] <= ~sync_s[c];
        end else begin
          cnt_q[c] <= cnt_q[c] + CntW'(1);
        end
      end
    end
  end

  for (genvar g = 0; g < Width; g++) begin : g_cnt_bound
    assert property (@(posedge clk_sys_i) disable iff (!rst_sys_ni)
                     cnt_q[g] < CntW'(DebounceCycles));
  end

`ifdef GPI_DEBOUNCE_IRQ_EN
  // Set terms come last so an edge arriving with a clear is never lost.
  always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
    if (!rst_sys_ni) begin
      irq_pending_o <= '0;
    end else begin
      irq_pending_o <= (irq_pending_o & ~irq_clear_i)
                     | (rise_o & irq_rise_en_i)
                     | (fall_o & irq_fall_en_i);
    end
  end

  assign irq_o = |irq_pending_o;
`endif

endmodule

// File: tb/tb_gpi_debounce.sv
// tb/tb_gpi_debounce.sv - scoreboard bench for gpi_debounce with a window-based reference model
module tb_gpi_debounce;
  localparam int W = 7;
  localparam int S = 2;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] gpi_i;
  logic [W-1:0] gpi_o;
  logic [W-1:0] rise_o;
  logic [W-1:0] fall_o;
`ifdef GPI_DEBOUNCE_IRQ_EN
  logic [W-1:0] ren;
  logic [W-1:0] fen;
  logic [W-1:0] clr;
  logic [W-1:0] pend;
  logic         irq;
`endif

  always #5 clk = ~clk;

  gpi_debounce #(
    .Width(W), .ClockFrequency(1_000_000), .DebounceUs(4), .SyncStages(S), .ResetValue('0)
  ) dut (
    .clk_sys_i(clk),
    .rst_sys_ni(rst_n),
    .gpi_i(gpi_i),
    .gpi_o(gpi_o),
    .rise_o(rise_o),
    .fall_o(fall_o)
`ifdef GPI_DEBOUNCE_IRQ_EN
    ,
    .irq_rise_en_i(ren),
    .irq_fall_en_i(fen),
    .irq_clear_i(clr),
    .irq_pending_o(pend),
    .irq_o(irq)
`endif
  );

  typedef struct packed {
    logic [W-1:0] o;
    logic [W-1:0] r;
    logic [W-1:0] f;
    logic [W-1:0] p;
  } exp_t;

  exp_t         sb[$];
  logic [W-1:0] hist[$];
  logic [W-1:0] m_out, m_rise, m_fall, m_pend;
  logic [W-1:0] nr, nf, np;
  bit           all_diff;
  int           n_chk = 0;
  int           n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Reference: a channel flips when its synchronised input (the pad value
  // sampled S edges earlier) has disagreed with the output for D edges running.
  always @(posedge clk) begin
    if (!rst_n) begin
      hist.delete();
      for (int i = 0; i < S + D; i++) hist.push_back('0);
      m_out  = '0;
      m_rise = '0;
      m_fall = '0;
      m_pend = '0;
    end else begin
      hist.push_back(gpi_i);
      if (hist.size() > 32) void'(hist.pop_front());
      np = m_pend;
`ifdef GPI_DEBOUNCE_IRQ_EN
      np = (m_pend & ~clr) | (m_rise & ren) | (m_fall & fen);
`endif
      nr = '0;
      nf = '0;
      for (int c = 0; c < W; c++) begin
        all_diff = 1'b1;
        for (int k = 0; k < D; k++)
          if (hist[hist.size() - 1 - S - k][c] == m_out[c]) all_diff = 1'b0;
        if (all_diff) begin
          m_out[c] = ~m_out[c];
          nr[c]    = m_out[c];
          nf[c]    = ~m_out[c];
        end
      end
      m_rise = nr;
      m_fall = nf;
      m_pend = np;
    end
    sb.push_back('{o: m_out, r: m_rise, f: m_fall, p: m_pend});
  end

  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("sb_gpi_o", gpi_o, e.o);
      check("sb_rise_o", rise_o, e.r);
      check("sb_fall_o", fall_o, e.f);
`ifdef GPI_DEBOUNCE_IRQ_EN
      check("sb_pending", pend, e.p);
      check("sb_irq", irq, |e.p);
`endif
    end
  end

  task automatic wait_pulse(input bit is_fall, input int ch, output bit found);
    found = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if ((is_fall ? fall_o[ch] : rise_o[ch]) == 1'b1) begin
        found = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    #1_000_000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    int  cnt;
    int  at;
    bit  found;
    rst_n = 1'b0;
    gpi_i = '0;
`ifdef GPI_DEBOUNCE_IRQ_EN
    ren = '0;
    fen = '0;
    clr = '0;
`endif
    repeat (3) tick();
    check("reset_state", {gpi_o, rise_o, fall_o}, '0);
    rst_n = 1'b1;
    repeat (10) tick();

    gpi_i[0] = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      tick();
      if (k == 5) check("step_edge5", {gpi_o, rise_o}, {7'h00, 7'h00});
      if (k == 6) check("step_edge6", {gpi_o, rise_o, fall_o}, {7'h01, 7'h01, 7'h00});
      if (k == 7) check("step_edge7", {gpi_o, rise_o}, {7'h01, 7'h00});
    end

    gpi_i[3] = 1'b1;
    repeat (3) tick();
    gpi_i[3] = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      check("glitch", {gpi_o, rise_o, fall_o}, {7'h01, 7'h00, 7'h00});
    end

    for (int i = 0; i < 5; i++) begin
      gpi_i[5] = ~gpi_i[5];
      if (i < 4) repeat (2) tick();
    end
    cnt = 0;
    at  = 0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (rise_o[5]) begin
        cnt++;
        at = k;
      end
    end
    check("bounce_pulses", cnt, 1);
    check("bounce_edge", at, 6);

`ifdef GPI_DEBOUNCE_IRQ_EN
    gpi_i[0] = 1'b0;
    wait_pulse(1'b1, 0, found);
    check("irq_fall_pulse", found, 1);
    tick();
    check("irq_fall_disabled", pend, 7'h00);
    fen = 7'h01;
    repeat (4) tick();
    check("irq_fall_en_late", irq, 1'b0);
    fen = '0;

    ren = 7'h01;
    gpi_i[0] = 1'b1;
    wait_pulse(1'b0, 0, found);
    check("irq_rise_pulse", found, 1);
    tick();
    check("irq_rise_set", {irq, pend}, {1'b1, 7'h01});

    gpi_i[0] = 1'b0;
    wait_pulse(1'b1, 0, found);
    check("irq_fall2_pulse", found, 1);
    gpi_i[0] = 1'b1;
    wait_pulse(1'b0, 0, found);
    check("irq_rise2_pulse", found, 1);
    clr = 7'h01;
    tick();
    clr = '0;
    check("irq_set_beats_clear", pend, 7'h01);
    tick();
    clr = 7'h01;
    tick();
    clr = '0;
    check("irq_clear_alone", {irq, pend}, {1'b0, 7'h00});
    ren = '0;
`endif

    gpi_i = 7'h01;
    repeat (10) tick();
    check("pre_reset_gpi_o", gpi_o, 7'h01);
    gpi_i = 7'h7F;
    repeat (4) tick();
    rst_n = 1'b0;
    #1;
    check("reset_async", {gpi_o, rise_o, fall_o}, '0);
`ifdef GPI_DEBOUNCE_IRQ_EN
    check("reset_async_irq", {irq, pend}, '0);
`endif
    repeat (2) tick();
    rst_n = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      tick();
      if (k == 5) check("release_edge5", {gpi_o, rise_o}, {7'h00, 7'h00});
      if (k == 6) check("release_edge6", {gpi_o, rise_o, fall_o}, {7'h7F, 7'h7F, 7'h00});
      if (k == 7) check("release_edge7", {gpi_o, rise_o}, {7'h7F, 7'h00});
    end

    for (int seg = 0; seg < 400; seg++) begin
      gpi_i = gpi_i ^ (W'($urandom) & W'($urandom));
`ifdef GPI_DEBOUNCE_IRQ_EN
      ren = W'($urandom);
      fen = W'($urandom);
`endif
      for (int h = 0, n = $urandom_range(1, 7); h < n; h++) begin
`ifdef GPI_DEBOUNCE_IRQ_EN
        clr = ($urandom_range(0, 3) == 0) ? W'($urandom) : '0;
`endif
        tick();
      end
    end

    repeat (3) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
